// File: rtl/secuenciador_de_melodia.sv
// Melody sequencer: walks a fixed note table, holding each pitch for its duration in
// cambiar_nota ticks with an optional silent gap. Optional macro REPETICION_EN loops the song.
module secuenciador_de_melodia #(
    parameter int LARGO       = 25,
    parameter int PAUSA_TICKS = 1
) (
    input  logic       clk_divisor,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic       detener,
    input  logic       cambiar_nota,
    output logic [3:0] indice_nota,
    output logic       silencio,
    output logic [4:0] direccion,
    output logic       reproduciendo,
    output logic       fin_cancion
);

    typedef enum logic [2:0] {
        REPOSO,
        CARGAR,
        SONAR,
        PAUSA,
        FIN
    } estado_t;

    localparam logic [4:0] ULTIMA = 5'(LARGO - 1);
    localparam logic [2:0] GAP    = 3'(PAUSA_TICKS);

    estado_t    estado, estado_sig;
    logic [2:0] cont, cont_sig;
    logic [3:0] indice_sig;
    logic       silencio_sig;
    logic [4:0] direccion_sig;
    logic       reproduciendo_sig;
    logic       fin_sig;
    logic       avanzar;

    logic [6:0] nota_act;
    logic [3:0] tono_act;
    logic [2:0] dur_act;

    // Each entry is {pitch[3:0], dur[2:0]}; the tail past the melody is silent filler.
    function automatic logic [6:0] entrada(input logic [4:0] dir);
        logic [6:0] e;
        case (dir)
            5'd0:    e = {4'd1,  3'd3};
            5'd1:    e = {4'd1,  3'd1};
            5'd2:    e = {4'd3,  3'd4};
            5'd3:    e = {4'd1,  3'd4};
            5'd4:    e = {4'd6,  3'd4};
            5'd5:    e = {4'd5,  3'd6};
            5'd6:    e = {4'd1,  3'd3};
            5'd7:    e = {4'd1,  3'd1};
            5'd8:    e = {4'd3,  3'd4};
            5'd9:    e = {4'd1,  3'd4};
            5'd10:   e = {4'd8,  3'd4};
            5'd11:   e = {4'd6,  3'd6};
            5'd12:   e = {4'd1,  3'd3};
            5'd13:   e = {4'd1,  3'd1};
            5'd14:   e = {4'd13, 3'd4};
            5'd15:   e = {4'd10, 3'd4};
            5'd16:   e = {4'd6,  3'd4};
            5'd17:   e = {4'd5,  3'd4};
            5'd18:   e = {4'd3,  3'd6};
            5'd19:   e = {4'd11, 3'd3};
            5'd20:   e = {4'd11, 3'd1};
            5'd21:   e = {4'd10, 3'd4};
            5'd22:   e = {4'd6,  3'd4};
            5'd23:   e = {4'd8,  3'd4};
            5'd24:   e = {4'd6,  3'd6};
            5'd25:   e = {4'd0,  3'd4};
            default: e = {4'd0,  3'd0};
        endcase
        return e;
    endfunction

    assign nota_act = entrada(direccion);
    assign tono_act = nota_act[6:3];
    assign dur_act  = (nota_act[2:0] == 3'd0) ? 3'd1 : nota_act[2:0];

    always_ff @(posedge clk_divisor) begin
        if (!rst_n) begin
            estado        <= REPOSO;
            cont          <= 3'd0;
            indice_nota   <= 4'd0;
            silencio      <= 1'b1;
            direccion     <= 5'd0;
            reproduciendo <= 1'b0;
            fin_cancion   <= 1'b0;
        end else begin
            estado        <= estado_sig;
            cont          <= cont_sig;
            indice_nota   <= indice_sig;
            silencio      <= silencio_sig;
            direccion     <= direccion_sig;
            reproduciendo <= reproduciendo_sig;
            fin_cancion   <= fin_sig;
        end
    end

    always_comb begin
        estado_sig        = estado;
        cont_sig          = cont;
        indice_sig        = indice_nota;
        silencio_sig      = silencio;
        direccion_sig     = direccion;
        reproduciendo_sig = reproduciendo;
        fin_sig           = 1'b0;
        avanzar           = 1'b0;

        unique case (estado)
            REPOSO: begin
                if (iniciar) begin
                    estado_sig    = CARGAR;
                    direccion_sig = 5'd0;
                end
            end
            CARGAR: begin
                indice_sig        = tono_act;
                silencio_sig      = (tono_act == 4'd0);
                cont_sig          = dur_act;
                reproduciendo_sig = 1'b1;
                estado_sig        = SONAR;
            end
            SONAR: begin
                if (cambiar_nota) begin
                    if (cont == 3'd1) begin
                        if (GAP != 3'd0) begin
                            estado_sig   = PAUSA;
                            silencio_sig = 1'b1;
                            indice_sig   = 4'd0;
                            cont_sig     = GAP;
                        end else begin
                            avanzar = 1'b1;
                        end
                    end else begin
                        cont_sig = cont - 3'd1;
                    end
                end
            end
            PAUSA: begin
                if (cambiar_nota) begin
                    if (cont == 3'd1) begin
                        avanzar = 1'b1;
                    end else begin
                        cont_sig = cont - 3'd1;
                    end
                end
            end
            FIN: begin
`ifdef REPETICION_EN
                direccion_sig = 5'd0;
                estado_sig    = CARGAR;
`else
                estado_sig        = REPOSO;
                reproduciendo_sig = 1'b0;
`endif
            end
            default: estado_sig = REPOSO;
        endcase

        // The end-of-song pulse is registered so it shows during the single FIN cycle.
        if (avanzar) begin
            if (direccion == ULTIMA) begin
                estado_sig   = FIN;
                fin_sig      = 1'b1;
                silencio_sig = 1'b1;
                indice_sig   = 4'd0;
                cont_sig     = 3'd0;
            end else begin
                direccion_sig = direccion + 5'd1;
                estado_sig    = CARGAR;
            end
        end

        // Stop overrides everything else, including a coincident start or tick.
        if (detener) begin
            estado_sig        = REPOSO;
            cont_sig          = 3'd0;
            indice_sig        = 4'd0;
            silencio_sig      = 1'b1;
            direccion_sig     = 5'd0;
            reproduciendo_sig = 1'b0;
            fin_sig           = 1'b0;
        end
    end

endmodule

// File: tb/tb_secuenciador_de_melodia.sv
// Bench for secuenciador_de_melodia: three instances (default, short gapless, two-entry song)
// driven by shared inputs; tick every 4 clocks.
`timescale 1ns/1ps
module tb_secuenciador_de_melodia;

    logic clk_divisor = 1'b0;
    logic rst_n, iniciar, detener, cambiar_nota;

    logic [3:0] idx_a, idx_b, idx_c;
    logic       sil_a, sil_b, sil_c;
    logic [4:0] dir_a, dir_b, dir_c;
    logic       rep_a, rep_b, rep_c;
    logic       fin_a, fin_b, fin_c;

    always #5 clk_divisor = ~clk_divisor;

    secuenciador_de_melodia #(.LARGO(25), .PAUSA_TICKS(1)) dut_a (
        .clk_divisor(clk_divisor), .rst_n(rst_n), .iniciar(iniciar), .detener(detener),
        .cambiar_nota(cambiar_nota), .indice_nota(idx_a), .silencio(sil_a),
        .direccion(dir_a), .reproduciendo(rep_a), .fin_cancion(fin_a));

    secuenciador_de_melodia #(.LARGO(4), .PAUSA_TICKS(0)) dut_b (
        .clk_divisor(clk_divisor), .rst_n(rst_n), .iniciar(iniciar), .detener(detener),
        .cambiar_nota(cambiar_nota), .indice_nota(idx_b), .silencio(sil_b),
        .direccion(dir_b), .reproduciendo(rep_b), .fin_cancion(fin_b));

    secuenciador_de_melodia #(.LARGO(2), .PAUSA_TICKS(1)) dut_c (
        .clk_divisor(clk_divisor), .rst_n(rst_n), .iniciar(iniciar), .detener(detener),
        .cambiar_nota(cambiar_nota), .indice_nota(idx_c), .silencio(sil_c),
        .direccion(dir_c), .reproduciendo(rep_c), .fin_cancion(fin_c));

    typedef struct {
        logic        rst;
        logic        ini;
        logic        det;
        int          ciclos;
        logic [11:0] esp;
        string       nombre;
    } vector_t;

    vector_t     tabla[$];
    logic [11:0] sb[$];
    logic [9:0]  eb[$];
    int          total = 0;
    int          pasados = 0;
    int unsigned fase = 0;
    logic        ultimo_tick = 1'b0;
    int          ticks, kk, caidas;
    logic        hecho;
    int          nota_tono[4] = '{1, 1, 3, 1};
    int          nota_dur[4]  = '{3, 1, 4, 4};

    function automatic logic [11:0] pk(input logic [3:0] i, input logic s, input logic [4:0] d,
                                       input logic r, input logic f);
        return {i, s, d, r, f};
    endfunction

    function automatic vector_t mk(input logic rst, input logic ini, input logic det, input int n,
                                   input logic [11:0] esp, input string nombre);
        vector_t v;
        v.rst = rst; v.ini = ini; v.det = det; v.ciclos = n; v.esp = esp; v.nombre = nombre;
        return v;
    endfunction

    task automatic chequear(input string nombre, input logic [31:0] real_v, input logic [31:0] esp);
        total++;
        if (real_v === esp) pasados++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, real_v, esp);
    endtask

    task automatic ciclo(input logic ini, input logic det);
        iniciar      = ini;
        detener      = det;
        cambiar_nota = (fase == 3);
        ultimo_tick  = cambiar_nota;
        fase         = (fase + 1) % 4;
        @(posedge clk_divisor);
        #1;
    endtask

    task automatic reiniciar();
        rst_n = 1'b0;
        ciclo(1'b0, 1'b0);
        ciclo(1'b0, 1'b0);
        rst_n = 1'b1;
        fase  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iniciar = 1'b0; detener = 1'b0; cambiar_nota = 1'b0;

        // Expected after each step: {indice, silencio, direccion, reproduciendo, fin}
        tabla.push_back(mk(1, 0, 0, 2, pk(0, 1, 0, 0, 0), "reset"));
        tabla.push_back(mk(0, 0, 0, 2, pk(0, 1, 0, 0, 0), "reposo_tick"));
        tabla.push_back(mk(0, 1, 0, 1, pk(0, 1, 0, 0, 0), "cargar"));
        tabla.push_back(mk(0, 0, 0, 1, pk(1, 0, 0, 1, 0), "nota0_on"));
        tabla.push_back(mk(0, 0, 0, 9, pk(1, 0, 0, 1, 0), "nota0_hold"));
        tabla.push_back(mk(0, 0, 0, 1, pk(0, 1, 0, 1, 0), "pausa0"));
        tabla.push_back(mk(0, 0, 0, 3, pk(0, 1, 0, 1, 0), "pausa0_hold"));
        tabla.push_back(mk(0, 0, 0, 1, pk(0, 1, 1, 1, 0), "dir1"));
        tabla.push_back(mk(0, 0, 0, 1, pk(1, 0, 1, 1, 0), "nota1_on"));
        tabla.push_back(mk(0, 1, 0, 1, pk(1, 0, 1, 1, 0), "ini_ignored"));
        tabla.push_back(mk(0, 0, 0, 1, pk(1, 0, 1, 1, 0), "nota1_hold"));
        tabla.push_back(mk(0, 0, 0, 1, pk(0, 1, 1, 1, 0), "pausa1"));
        tabla.push_back(mk(0, 0, 0, 4, pk(0, 1, 2, 1, 0), "dir2"));
        tabla.push_back(mk(0, 0, 0, 1, pk(3, 0, 2, 1, 0), "nota2_on"));
        tabla.push_back(mk(0, 0, 0, 2, pk(3, 0, 2, 1, 0), "nota2_hold"));
        tabla.push_back(mk(0, 1, 1, 1, pk(0, 1, 0, 0, 0), "detener"));
        tabla.push_back(mk(0, 0, 0, 8, pk(0, 1, 0, 0, 0), "detener_idle"));
        tabla.push_back(mk(0, 1, 0, 1, pk(0, 1, 0, 0, 0), "restart_cargar"));
        tabla.push_back(mk(0, 0, 0, 1, pk(1, 0, 0, 1, 0), "restart_nota0"));
        tabla.push_back(mk(0, 0, 0, 6, pk(1, 0, 0, 1, 0), "restart_hold"));
        tabla.push_back(mk(1, 0, 0, 1, pk(0, 1, 0, 0, 0), "reset_mid_note"));
        tabla.push_back(mk(0, 0, 0, 4, pk(0, 1, 0, 0, 0), "post_reset_idle"));
        tabla.push_back(mk(0, 1, 0, 1, pk(0, 1, 0, 0, 0), "post_reset_cargar"));
        tabla.push_back(mk(0, 0, 0, 1, pk(1, 0, 0, 1, 0), "post_reset_nota0"));

        fase = 0;
        for (int v = 0; v < tabla.size(); v++) begin
            rst_n = !tabla[v].rst;
            sb.push_back(tabla[v].esp);
            for (int c = 0; c < tabla[v].ciclos; c++)
                ciclo((c == 0) ? tabla[v].ini : 1'b0, (c == 0) ? tabla[v].det : 1'b0);
            rst_n = 1'b1;
            chequear(tabla[v].nombre, 32'({idx_a, sil_a, dir_a, rep_a, fin_a}), 32'(sb.pop_front()));
        end

        // Gapless four-note song: pitch/address seen at every tick, end pulse right after tick 12.
        reiniciar();
        ciclo(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < nota_dur[i]; t++)
                eb.push_back({4'(nota_tono[i]), 1'b0, 5'(i)});
        ticks = 0;
        hecho = 1'b0;
        for (int c = 0; c < 200 && !hecho; c++) begin
            if (fase == 3) begin
                ticks++;
                if (eb.size() > 0) chequear("nota_b", 32'({idx_b, sil_b, dir_b}), 32'(eb.pop_front()));
                else chequear("tick_extra_b", 32'(ticks), 32'd12);
            end
            ciclo(1'b0, 1'b0);
            if (fin_b) hecho = 1'b1;
        end
        chequear("fin_b_visto", 32'(hecho), 32'd1);
        chequear("fin_b_ticks", 32'(ticks), 32'd12);
        chequear("fin_b_al_tick", 32'(ultimo_tick), 32'd1);
        chequear("fin_b_salidas", 32'({idx_b, sil_b, rep_b}), 32'({4'd0, 1'b1, 1'b1}));
        ciclo(1'b0, 1'b0);
        chequear("fin_b_pulso", 32'({fin_b, rep_b, idx_b, sil_b}), 32'({1'b0, 1'b0, 4'd0, 1'b1}));

        // Two-entry song with gap: end of song after entry 1 gap.
        reiniciar();
        ciclo(1'b1, 1'b0);
        kk = 1;
        caidas = 0;
        hecho = 1'b0;
        for (int c = 0; c < 200 && !hecho; c++) begin
            ciclo(1'b0, 1'b0);
            kk++;
            if (!rep_c) caidas++;
            if (fin_c) hecho = 1'b1;
        end
        chequear("fin_c_visto", 32'(hecho), 32'd1);
        chequear("fin_c_ciclo", 32'(kk), 32'd24);
        chequear("fin_c_dir", 32'({dir_c, idx_c, sil_c}), 32'({5'd1, 4'd0, 1'b1}));
`ifdef REPETICION_EN
        ciclo(1'b0, 1'b0);
        if (!rep_c) caidas++;
        chequear("loop_dir0", 32'({dir_c, rep_c, fin_c}), 32'({5'd0, 1'b1, 1'b0}));
        ciclo(1'b0, 1'b0);
        if (!rep_c) caidas++;
        chequear("loop_nota0", 32'({idx_c, sil_c, rep_c}), 32'({4'd1, 1'b0, 1'b1}));
        for (int c = 0; c < 40; c++) begin
            ciclo(1'b0, 1'b0);
            if (!rep_c) caidas++;
        end
        chequear("loop_rep_continuo", 32'(caidas), 32'd0);
        ciclo(1'b0, 1'b1);
        chequear("loop_detener", 32'({rep_c, idx_c, sil_c, dir_c, fin_c}),
                 32'({1'b0, 4'd0, 1'b1, 5'd0, 1'b0}));
`else
        chequear("rep_hasta_fin", 32'(caidas), 32'd0);
        ciclo(1'b0, 1'b0);
        chequear("fin_c_reposo", 32'({rep_c, fin_c, idx_c, sil_c}), 32'({1'b0, 1'b0, 4'd0, 1'b1}));
        caidas = 0;
        for (int c = 0; c < 12; c++) begin
            ciclo(1'b0, 1'b0);
            if (rep_c || fin_c || !sil_c || idx_c != 4'd0) caidas++;
        end
        chequear("fin_c_held", 32'(caidas), 32'd0);
`endif

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
